// File: rtl/sram_test_pkg.sv
// ---------------------------------------------------------------------------
// sram_test_pkg
// Shared definitions for the SRAM self-test blocks.
//   seqState_t : sequencer state encoding, also reported on test_state
//   idxBits()  : width helper giving clog2(n) with a floor of one bit
// ---------------------------------------------------------------------------
package sram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READ     = 3'd3,
        ST_NEXT_PAT = 3'd4,
        ST_DONE     = 3'd5,
        ST_HALT     = 3'd6
    } seqState_t;

    function automatic int idxBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_test_err_log.sv
// ---------------------------------------------------------------------------
// sram_test_err_log
// Failure log for the SRAM test sequencer: a saturating failure counter plus
// the address and pattern number of the first failure since the last clear.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_clear               synchronous clear at test start
//   i_logFail             a qualified miscompare to record this cycle
//   i_addr, i_patIdx      where the miscompare happened
//   o_errorCount          saturating failure count
//   o_firstFailAddr       address of the first recorded failure
//   o_firstFailPattern    pattern number of the first recorded failure
// ---------------------------------------------------------------------------
module sram_test_err_log #(
    parameter int ADDR_BITS = 20,
    parameter int PAT_BITS  = 2,
    parameter int ERR_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_logFail,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [PAT_BITS-1:0]  i_patIdx,
    output logic [ERR_BITS-1:0]  o_errorCount,
    output logic [ADDR_BITS-1:0] o_firstFailAddr,
    output logic [PAT_BITS-1:0]  o_firstFailPattern
);

    logic [ERR_BITS-1:0]  r_errorCount;
    logic [ADDR_BITS-1:0] r_firstFailAddr;
    logic [PAT_BITS-1:0]  r_firstFailPattern;

    // A zero count means nothing has been logged since the last clear, so it
    // doubles as the "first failure" qualifier; saturation never returns to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errorCount       <= '0;
            r_firstFailAddr    <= '0;
            r_firstFailPattern <= '0;
        end else if (i_clear) begin
            r_errorCount       <= '0;
            r_firstFailAddr    <= '0;
            r_firstFailPattern <= '0;
        end else if (i_logFail) begin
            if (r_errorCount != '1) begin
                r_errorCount <= r_errorCount + ERR_BITS'(1);
            end
            if (r_errorCount == '0) begin
                r_firstFailAddr    <= i_addr;
                r_firstFailPattern <= i_patIdx;
            end
        end
    end

    assign o_errorCount       = r_errorCount;
    assign o_firstFailAddr    = r_firstFailAddr;
    assign o_firstFailPattern = r_firstFailPattern;

endmodule

// File: rtl/sram_test_sequencer.sv
// ---------------------------------------------------------------------------
// sram_test_sequencer
// March-style SRAM test controller. For each pattern it sweeps the address
// generator once writing, waits a few settle cycles, sweeps again reading
// with the checker enabled, then advances the pattern generator.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        begin a test (IDLE/DONE) / synchronous return to IDLE
//   addr_done, addr     address generator at last address / current address
//   test_fail           checker miscompare for the current read
//   read_only, next_addr, addr_gen_reset, pattern_gen_reset, next_pattern,
//   enable_checker      control strobes to the generators and checker
//   pattern_idx, iteration, error_count, first_fail_addr, first_fail_pattern
//                       progress and failure log
//   busy, test_done, test_pass, test_state   status
// ---------------------------------------------------------------------------
module sram_test_sequencer
    import sram_test_pkg::*;
#(
    parameter int ADDR_BITS     = 20,
    parameter int NUM_PATTERNS  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int STOP_ON_FAIL  = 1,
    parameter int LOOP_FOREVER  = 0,
    parameter int ERR_BITS      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              addr_done,
    input  logic [ADDR_BITS-1:0]              addr,
    input  logic                              test_fail,
    output logic                              read_only,
    output logic                              next_addr,
    output logic                              addr_gen_reset,
    output logic                              pattern_gen_reset,
    output logic                              next_pattern,
    output logic                              enable_checker,
    output logic [idxBits(NUM_PATTERNS)-1:0]  pattern_idx,
    output logic [15:0]                       iteration,
    output logic [ERR_BITS-1:0]               error_count,
    output logic [ADDR_BITS-1:0]              first_fail_addr,
    output logic [idxBits(NUM_PATTERNS)-1:0]  first_fail_pattern,
    output logic                              busy,
    output logic                              test_done,
    output logic                              test_pass,
    output logic [2:0]                        test_state
);

    localparam int PAT_BITS = idxBits(NUM_PATTERNS);
    localparam int CNT_BITS = idxBits(SETTLE_CYCLES + 1);
    localparam logic [PAT_BITS-1:0] LAST_PAT    = PAT_BITS'(NUM_PATTERNS - 1);
    localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_CYCLES - 1);

    seqState_t           r_state;
    seqState_t           w_nextState;
    logic [CNT_BITS-1:0] r_settleCnt;
    logic [PAT_BITS-1:0] r_patIdx;
    logic [15:0]         r_iteration;
    logic [ERR_BITS-1:0] w_errorCount;
    logic                w_lastPat;
    logic                w_startAccept;
    logic                w_logFail;
    logic                w_haltReq;

    assign w_lastPat     = (r_patIdx == LAST_PAT);
    assign w_startAccept = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
    // A failure coinciding with abort is dropped: abort outranks everything.
    assign w_logFail     = (r_state == ST_READ) && test_fail && !abort;
    assign w_haltReq     = w_logFail && (STOP_ON_FAIL != 0);

    // Next-state selection. A halt request beats addr_done so a miscompare
    // on the last address still stops the test.
    always_comb begin
        w_nextState = r_state;
        if (abort) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (start) w_nextState = ST_WRITE;
                ST_WRITE:    if (addr_done) w_nextState = ST_SETTLE;
                ST_SETTLE:   if (r_settleCnt == SETTLE_LAST) w_nextState = ST_READ;
                ST_READ: begin
                    if (w_haltReq) begin
                        w_nextState = ST_HALT;
                    end else if (addr_done) begin
                        if (w_lastPat && LOOP_FOREVER == 0) w_nextState = ST_DONE;
                        else                                w_nextState = ST_NEXT_PAT;
                    end
                end
                ST_NEXT_PAT: w_nextState = ST_WRITE;
                ST_DONE:     if (start) w_nextState = ST_WRITE;
                ST_HALT:     w_nextState = ST_HALT;
                default:     w_nextState = ST_IDLE;
            endcase
        end
    end

    // State, settle timer and pattern/iteration bookkeeping. The pattern
    // index advances as NEXT_PAT is left, so it stays stable while the
    // pattern generator is being stepped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_settleCnt <= '0;
            r_patIdx    <= '0;
            r_iteration <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_SETTLE && w_nextState == ST_SETTLE) begin
                r_settleCnt <= r_settleCnt + CNT_BITS'(1);
            end else begin
                r_settleCnt <= '0;
            end
            if (w_startAccept) begin
                r_patIdx    <= '0;
                r_iteration <= '0;
            end else if (r_state == ST_NEXT_PAT && !abort) begin
                if (w_lastPat) begin
                    r_patIdx <= '0;
                    if (r_iteration != 16'hFFFF) begin
                        r_iteration <= r_iteration + 16'd1;
                    end
                end else begin
                    r_patIdx <= r_patIdx + PAT_BITS'(1);
                end
            end
        end
    end

    sram_test_err_log #(
        .ADDR_BITS (ADDR_BITS),
        .PAT_BITS  (PAT_BITS),
        .ERR_BITS  (ERR_BITS)
    ) u_errLog (
        .clk                (clk),
        .reset              (reset),
        .i_clear            (w_startAccept),
        .i_logFail          (w_logFail),
        .i_addr             (addr),
        .i_patIdx           (r_patIdx),
        .o_errorCount       (w_errorCount),
        .o_firstFailAddr    (first_fail_addr),
        .o_firstFailPattern (first_fail_pattern)
    );

    // Moore decode of the control strobes from registered state only.
    // DONE parks both generators in reset, like IDLE; HALT freezes them so
    // the failing address stays visible.
    always_comb begin
        read_only         = 1'b0;
        next_addr         = 1'b0;
        addr_gen_reset    = 1'b0;
        pattern_gen_reset = 1'b0;
        next_pattern      = 1'b0;
        enable_checker    = 1'b0;
        busy              = 1'b0;
        test_done         = 1'b0;
        test_pass         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                addr_gen_reset    = 1'b1;
                pattern_gen_reset = 1'b1;
            end
            ST_WRITE: begin
                next_addr = 1'b1;
                busy      = 1'b1;
            end
            ST_SETTLE: begin
                read_only      = 1'b1;
                busy           = 1'b1;
                addr_gen_reset = (r_settleCnt == '0);
            end
            ST_READ: begin
                read_only      = 1'b1;
                next_addr      = 1'b1;
                enable_checker = 1'b1;
                busy           = 1'b1;
            end
            ST_NEXT_PAT: begin
                next_pattern      = 1'b1;
                addr_gen_reset    = 1'b1;
                busy              = 1'b1;
                pattern_gen_reset = w_lastPat;
            end
            ST_DONE: begin
                test_done         = 1'b1;
                test_pass         = (w_errorCount == '0);
                addr_gen_reset    = 1'b1;
                pattern_gen_reset = 1'b1;
            end
            ST_HALT: begin
                test_done = 1'b1;
            end
            default: begin
                addr_gen_reset    = 1'b1;
                pattern_gen_reset = 1'b1;
            end
        endcase
    end

    assign pattern_idx = r_patIdx;
    assign iteration   = r_iteration;
    assign error_count = w_errorCount;
    assign test_state  = r_state;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sram_test_sequencer
// Three sequencer instances with different parameter sets share one clock:
//   dut 0: NUM_PATTERNS=2, STOP_ON_FAIL=1, LOOP_FOREVER=0, ERR_BITS=16
//   dut 1: NUM_PATTERNS=2, STOP_ON_FAIL=0, LOOP_FOREVER=0, ERR_BITS=4
//   dut 2: NUM_PATTERNS=3, STOP_ON_FAIL=1, LOOP_FOREVER=1, ERR_BITS=16
// The bench plays the address generator and checker; failures come from a
// per-dut (pattern, address) mask.
// ---------------------------------------------------------------------------
module tb_sram_test_sequencer;
    import sram_test_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;

    logic       iStart[NDUT], iAbort[NDUT], iAddrDone[NDUT], iFail[NDUT];
    logic [7:0] iAddr[NDUT];
    logic [2:0] oSt[NDUT];
    logic       oRo[NDUT], oNa[NDUT], oAgr[NDUT], oPgr[NDUT], oNp[NDUT];
    logic       oEc[NDUT], oBusy[NDUT], oDone[NDUT], oPass[NDUT];
    logic [7:0] oPat[NDUT], oFfp[NDUT], oFfa[NDUT];
    logic [15:0] oIter[NDUT], oErr[NDUT];

    int errors = 0;
    int checks = 0;
    int lastAddr[NDUT];
    int mAddr[NDUT];
    logic failMask[NDUT][4][16];
    logic [6:0] trace[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int NP   = (g == 2) ? 3 : 2;
        localparam int STOP = (g == 1) ? 0 : 1;
        localparam int LOOP = (g == 2) ? 1 : 0;
        localparam int EB   = (g == 1) ? 4 : 16;
        localparam int PW   = idxBits(NP);
        logic [PW-1:0] wPat, wFfp;
        logic [EB-1:0] wErr;
        sram_test_sequencer #(
            .ADDR_BITS(8), .NUM_PATTERNS(NP), .SETTLE_CYCLES(2),
            .STOP_ON_FAIL(STOP), .LOOP_FOREVER(LOOP), .ERR_BITS(EB)
        ) dut (
            .clk(clk), .reset(reset), .start(iStart[g]), .abort(iAbort[g]),
            .addr_done(iAddrDone[g]), .addr(iAddr[g]), .test_fail(iFail[g]),
            .read_only(oRo[g]), .next_addr(oNa[g]), .addr_gen_reset(oAgr[g]),
            .pattern_gen_reset(oPgr[g]), .next_pattern(oNp[g]),
            .enable_checker(oEc[g]), .pattern_idx(wPat), .iteration(oIter[g]),
            .error_count(wErr), .first_fail_addr(oFfa[g]),
            .first_fail_pattern(wFfp), .busy(oBusy[g]), .test_done(oDone[g]),
            .test_pass(oPass[g]), .test_state(oSt[g])
        );
        assign oPat[g] = 8'(wPat);
        assign oFfp[g] = 8'(wFfp);
        assign oErr[g] = 16'(wErr);
    end

    // test_fail follows the mask whatever the state, so the DUT must qualify it
    task automatic drive(input int k);
        iAddr[k]     = 8'(mAddr[k]);
        iAddrDone[k] = (mAddr[k] == lastAddr[k]);
        iFail[k]     = failMask[k][oPat[k][1:0]][mAddr[k]];
    endtask

    task automatic tick(input int k);
        logic pAgr, pNa;
        pAgr = oAgr[k];
        pNa  = oNa[k];
        @(posedge clk);
        #1;
        if (pAgr) mAddr[k] = 0;
        else if (pNa && mAddr[k] != lastAddr[k]) mAddr[k] = mAddr[k] + 1;
        drive(k);
    endtask

    task automatic setupRun(input int k, input int nAddr);
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 16; a++) failMask[k][p][a] = 1'b0;
        lastAddr[k] = nAddr - 1;
        mAddr[k]    = 0;
        drive(k);
    endtask

    task automatic runTest(input int k, output int nextPulses,
                           output logic [15:0] errAtStart, output logic timedOut);
        iStart[k] = 1'b1;
        tick(k);
        iStart[k] = 1'b0;
        drive(k);
        errAtStart = oErr[k];
        trace.delete();
        nextPulses = 0;
        timedOut   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            trace.push_back({oSt[k], oRo[k], oNa[k], oAgr[k], oEc[k]});
            if (oNp[k]) nextPulses++;
            if (oSt[k] == 3'(ST_DONE) || oSt[k] == 3'(ST_HALT)) begin
                timedOut = 1'b0;
                break;
            end
            tick(k);
        end
    endtask

    task automatic doAbort(input int k);
        iAbort[k] = 1'b1;
        tick(k);
        iAbort[k] = 1'b0;
        drive(k);
    endtask

    // Reference: reads happen pattern-major, address-minor, so the first
    // failure is the first set mask bit in that order.
    task automatic modelFails(input int k, input int np, input int nAddr, input int errMax,
                              output int fp, output int fa, output int cnt);
        fp = -1; fa = -1; cnt = 0;
        for (int p = 0; p < np; p++)
            for (int a = 0; a < nAddr; a++)
                if (failMask[k][p][a]) begin
                    if (fp < 0) begin fp = p; fa = a; end
                    cnt++;
                end
        if (cnt > errMax) cnt = errMax;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (oSt[k] !== 3'(ST_IDLE)) begin errors++; $display("[TB] FAIL reset_state dut%0d: got %0d expected %0d", k, oSt[k], ST_IDLE); end
            checks++;
            if ({oAgr[k], oPgr[k]} !== 2'b11) begin errors++; $display("[TB] FAIL reset_gen_resets dut%0d: got %b expected 11", k, {oAgr[k], oPgr[k]}); end
            checks++;
            if ({oRo[k], oNa[k], oNp[k], oEc[k], oBusy[k], oDone[k], oPass[k]} !== 7'b0) begin
                errors++; $display("[TB] FAIL reset_strobes dut%0d: got %b expected 0000000", k, {oRo[k], oNa[k], oNp[k], oEc[k], oBusy[k], oDone[k], oPass[k]});
            end
            checks++;
            if (oErr[k] !== 16'd0 || oIter[k] !== 16'd0) begin errors++; $display("[TB] FAIL reset_counters dut%0d: got err=%0d iter=%0d expected 0 0", k, oErr[k], oIter[k]); end
            checks++;
            if (oFfa[k] !== 8'd0 || oFfp[k] !== 8'd0 || oPat[k] !== 8'd0) begin
                errors++; $display("[TB] FAIL reset_capture dut%0d: got ffa=%0d ffp=%0d pat=%0d expected 0 0 0", k, oFfa[k], oFfp[k], oPat[k]);
            end
        end
    endtask

    task automatic test_clean_run();
        logic [6:0] expTr[$];
        int np; logic [15:0] e0; logic to;
        setupRun(0, 4);
        for (int p = 0; p < 2; p++) begin
            repeat (4) expTr.push_back({3'(ST_WRITE), 4'b0100});
            expTr.push_back({3'(ST_SETTLE), 4'b1010});
            expTr.push_back({3'(ST_SETTLE), 4'b1000});
            repeat (4) expTr.push_back({3'(ST_READ), 4'b1101});
            if (p == 0) expTr.push_back({3'(ST_NEXT_PAT), 4'b0010});
        end
        expTr.push_back({3'(ST_DONE), 4'b0000});
        runTest(0, np, e0, to);
        checks++;
        if (to !== 1'b0 || trace.size() != expTr.size()) begin
            errors++; $display("[TB] FAIL clean_length: got %0d cycles (timeout=%b) expected %0d", trace.size(), to, expTr.size());
        end
        for (int i = 0; i < trace.size() && i < expTr.size(); i++) begin
            checks++;
            if (i == expTr.size() - 1) begin
                if (trace[i][6:4] !== expTr[i][6:4]) begin errors++; $display("[TB] FAIL clean_final_state: got %0d expected %0d", trace[i][6:4], expTr[i][6:4]); end
            end else if (trace[i] !== expTr[i]) begin
                errors++; $display("[TB] FAIL clean_trace[%0d]: got st=%0d flags=%b expected st=%0d flags=%b", i, trace[i][6:4], trace[i][3:0], expTr[i][6:4], expTr[i][3:0]);
            end
        end
        checks++;
        if (np != 1) begin errors++; $display("[TB] FAIL clean_next_pattern_pulses: got %0d expected 1", np); end
        checks++;
        if ({oDone[0], oPass[0], oBusy[0]} !== 3'b110 || oErr[0] !== 16'd0) begin
            errors++; $display("[TB] FAIL clean_status: got done/pass/busy=%b err=%0d expected 110 0", {oDone[0], oPass[0], oBusy[0]}, oErr[0]);
        end
    endtask

    task automatic test_stop_on_fail();
        int np, fp, fa, cnt, n; logic [15:0] e0; logic to;
        setupRun(0, 4);
        failMask[0][1][3] = 1'b1;
        runTest(0, np, e0, to);
        checks++;
        if (oSt[0] !== 3'(ST_HALT)) begin errors++; $display("[TB] FAIL stop_state: got %0d expected %0d", oSt[0], ST_HALT); end
        checks++;
        if (oFfa[0] !== 8'h03 || oFfp[0] !== 8'd1 || oErr[0] !== 16'd1) begin
            errors++; $display("[TB] FAIL stop_log: got ffa=%0d ffp=%0d err=%0d expected 3 1 1", oFfa[0], oFfp[0], oErr[0]);
        end
        checks++;
        if ({oDone[0], oPass[0], oNa[0]} !== 3'b100) begin errors++; $display("[TB] FAIL stop_status: got done/pass/next_addr=%b expected 100", {oDone[0], oPass[0], oNa[0]}); end
        iStart[0] = 1'b1;
        repeat (3) tick(0);
        iStart[0] = 1'b0;
        tick(0);
        checks++;
        if (oSt[0] !== 3'(ST_HALT)) begin errors++; $display("[TB] FAIL halt_ignores_start: got %0d expected %0d", oSt[0], ST_HALT); end
        doAbort(0);
        checks++;
        if (oSt[0] !== 3'(ST_IDLE) || oErr[0] !== 16'd1 || oFfa[0] !== 8'h03) begin
            errors++; $display("[TB] FAIL abort_retains_log: got st=%0d err=%0d ffa=%0d expected %0d 1 3", oSt[0], oErr[0], oFfa[0], ST_IDLE);
        end
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 8);
            setupRun(0, n);
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < n; a++) failMask[0][p][a] = ($urandom_range(0, 5) == 0);
            failMask[0][$urandom_range(0, 1)][$urandom_range(0, n - 1)] = 1'b1;
            drive(0);
            modelFails(0, 2, n, 65535, fp, fa, cnt);
            runTest(0, np, e0, to);
            checks++;
            if (oSt[0] !== 3'(ST_HALT) || oErr[0] !== 16'd1 || oFfa[0] !== 8'(fa) || oFfp[0] !== 8'(fp)) begin
                errors++; $display("[TB] FAIL stop_random[%0d]: got st=%0d err=%0d ffa=%0d ffp=%0d expected %0d 1 %0d %0d", r, oSt[0], oErr[0], oFfa[0], oFfp[0], ST_HALT, fa, fp);
            end
            doAbort(0);
        end
    endtask

    task automatic test_same_cycle();
        int np, n; logic [15:0] e0; logic to;
        for (int p = 0; p < 2; p++) begin
            n = $urandom_range(2, 8);
            setupRun(0, n);
            failMask[0][p][n - 1] = 1'b1;
            drive(0);
            runTest(0, np, e0, to);
            checks++;
            if (oSt[0] !== 3'(ST_HALT) || np != p || oFfp[0] !== 8'(p) || oFfa[0] !== 8'(n - 1)) begin
                errors++; $display("[TB] FAIL fail_with_addr_done p%0d: got st=%0d pulses=%0d ffp=%0d ffa=%0d expected %0d %0d %0d %0d", p, oSt[0], np, oFfp[0], oFfa[0], ST_HALT, p, p, n - 1);
            end
            doAbort(0);
        end
    endtask

    task automatic test_continue();
        int np, fp, fa, cnt, n, placed, pp, aa; logic [15:0] e0; logic to;
        n = $urandom_range(3, 8);
        setupRun(1, n);
        placed = 0;
        while (placed < 3) begin
            pp = $urandom_range(0, 1);
            aa = $urandom_range(0, n - 1);
            if (!failMask[1][pp][aa]) begin failMask[1][pp][aa] = 1'b1; placed++; end
        end
        drive(1);
        modelFails(1, 2, n, 15, fp, fa, cnt);
        runTest(1, np, e0, to);
        checks++;
        if (oSt[1] !== 3'(ST_DONE) || oErr[1] !== 16'(cnt) || oPass[1] !== 1'b0 || oDone[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL continue_done: got st=%0d err=%0d pass=%b done=%b expected %0d %0d 0 1", oSt[1], oErr[1], oPass[1], oDone[1], ST_DONE, cnt);
        end
        checks++;
        if (oFfa[1] !== 8'(fa) || oFfp[1] !== 8'(fp) || np != 1) begin
            errors++; $display("[TB] FAIL continue_first_fail: got ffa=%0d ffp=%0d pulses=%0d expected %0d %0d 1", oFfa[1], oFfp[1], np, fa, fp);
        end
        setupRun(1, 10);
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 10; a++) failMask[1][p][a] = 1'b1;
        drive(1);
        modelFails(1, 2, 10, 15, fp, fa, cnt);
        runTest(1, np, e0, to);
        checks++;
        if (e0 !== 16'd0) begin errors++; $display("[TB] FAIL restart_clears_log: got err=%0d expected 0", e0); end
        checks++;
        if (oSt[1] !== 3'(ST_DONE) || oErr[1] !== 16'(cnt) || oFfa[1] !== 8'(fa) || oFfp[1] !== 8'(fp)) begin
            errors++; $display("[TB] FAIL err_saturation: got st=%0d err=%0d ffa=%0d ffp=%0d expected %0d %0d %0d %0d", oSt[1], oErr[1], oFfa[1], oFfp[1], ST_DONE, cnt, fa, fp);
        end
    endtask

    task automatic test_loop();
        int npSeen, wraps, badWrap;
        setupRun(2, $urandom_range(2, 4));
        iStart[2] = 1'b1;
        tick(2);
        iStart[2] = 1'b0;
        drive(2);
        npSeen = 0; wraps = 0; badWrap = 0;
        for (int c = 0; c < 3000; c++) begin
            if (oSt[2] == 3'(ST_NEXT_PAT)) begin
                npSeen++;
                if (oPgr[2]) wraps++;
                if (oPgr[2] !== (oPat[2] == 8'd2)) badWrap++;
            end
            tick(2);
            if (npSeen == 9) break;
        end
        checks++;
        if (npSeen != 9 || wraps != 3 || badWrap != 0) begin
            errors++; $display("[TB] FAIL loop_wraps: got completions=%0d wraps=%0d misplaced=%0d expected 9 3 0", npSeen, wraps, badWrap);
        end
        checks++;
        if (oSt[2] !== 3'(ST_WRITE) || oIter[2] !== 16'd3 || oPat[2] !== 8'd0) begin
            errors++; $display("[TB] FAIL loop_iteration: got st=%0d iter=%0d pat=%0d expected %0d 3 0", oSt[2], oIter[2], oPat[2], ST_WRITE);
        end
        doAbort(2);
    endtask

    task automatic test_reset_abort();
        int c;
        setupRun(0, 4);
        iStart[0] = 1'b1;
        tick(0);
        iStart[0] = 1'b0;
        drive(0);
        c = 0;
        while (oSt[0] != 3'(ST_SETTLE) && c < 40) begin tick(0); c++; end
        checks++;
        if (oSt[0] !== 3'(ST_SETTLE)) begin errors++; $display("[TB] FAIL reach_settle: got %0d expected %0d", oSt[0], ST_SETTLE); end
        reset = 1'b1;
        #1;
        checks++;
        if (oSt[0] !== 3'(ST_IDLE) || oAgr[0] !== 1'b1 || oBusy[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_test: got st=%0d agr=%b busy=%b expected %0d 1 0", oSt[0], oAgr[0], oBusy[0], ST_IDLE);
        end
        checks++;
        if (oErr[1] !== 16'd0 || oFfa[1] !== 8'd0 || oIter[2] !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_clears_logs: got err1=%0d ffa1=%0d iter2=%0d expected 0 0 0", oErr[1], oFfa[1], oIter[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        setupRun(0, 4);
        iStart[0] = 1'b1;
        tick(0);
        iStart[0] = 1'b0;
        drive(0);
        checks++;
        if (oSt[0] !== 3'(ST_WRITE)) begin errors++; $display("[TB] FAIL restart_write: got %0d expected %0d", oSt[0], ST_WRITE); end
        doAbort(0);
        checks++;
        if (oSt[0] !== 3'(ST_IDLE) || oAgr[0] !== 1'b1 || oBusy[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_from_write: got st=%0d agr=%b busy=%b expected %0d 1 0", oSt[0], oAgr[0], oBusy[0], ST_IDLE);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            iStart[k] = 1'b0; iAbort[k] = 1'b0; iAddrDone[k] = 1'b0;
            iFail[k] = 1'b0; iAddr[k] = 8'd0; mAddr[k] = 0; lastAddr[k] = 3;
            for (int p = 0; p < 4; p++)
                for (int a = 0; a < 16; a++) failMask[k][p][a] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_clean_run();
        test_stop_on_fail();
        test_same_cycle();
        test_continue();
        test_loop();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
